// File: rtl/argon_regfile_sb_if.sv
// Register-file request/response bundle: operand reads, destination
// reservations, write-back, flag updates and the scoreboard view.
interface argon_regfile_sb_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int FLAG_BITS  = 8
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic                  i_rd_req;
  logic [IDX_W-1:0]      i_rd_idx_a;
  logic [IDX_W-1:0]      i_rd_idx_b;
  logic                  o_rd_stall;
  logic                  o_rd_valid;
  logic [DATA_WIDTH-1:0] o_rd_data_a;
  logic [DATA_WIDTH-1:0] o_rd_data_b;

  logic                  i_rsv_valid;
  logic [IDX_W-1:0]      i_rsv_idx;
  logic                  o_rsv_ready;

  logic                  i_wr_valid;
  logic [IDX_W-1:0]      i_wr_idx;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  i_flag_wr;
  logic [FLAG_BITS-1:0]  i_flag_data;

  logic [NUM_REGS-1:0]   o_busy;

  modport slave (
    input  i_rd_req, i_rd_idx_a, i_rd_idx_b,
    output o_rd_stall, o_rd_valid, o_rd_data_a, o_rd_data_b,
    input  i_rsv_valid, i_rsv_idx,
    output o_rsv_ready,
    input  i_wr_valid, i_wr_idx, i_wr_data, i_flag_wr, i_flag_data,
    output o_busy
  );

  modport master (
    output i_rd_req, i_rd_idx_a, i_rd_idx_b,
    input  o_rd_stall, o_rd_valid, o_rd_data_a, o_rd_data_b,
    output i_rsv_valid, i_rsv_idx,
    input  o_rsv_ready,
    output i_wr_valid, i_wr_idx, i_wr_data, i_flag_wr, i_flag_data,
    input  o_busy
  );
endinterface

// File: rtl/argon_regfile_sb.sv
// Scoreboarded register file: r0 hard zero, per-register busy bits, 1-cycle reads.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data into reads.

module argon_regfile_sb_cell #(
  parameter int DATA_WIDTH = 16,
  parameter int FLAG_BITS  = 8
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_flag_en,
  input  logic [FLAG_BITS-1:0]  i_flag_data,
  input  logic                  i_rsv_set,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy
);
  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic                  busy_d, busy_q;

  // Flag field is applied after the full write so it owns the low bits.
  always_comb begin
    data_d = data_q;
    if (i_wr_en)   data_d = i_wr_data;
    if (i_flag_en) data_d[FLAG_BITS-1:0] = i_flag_data;
    busy_d = busy_q;
    if (i_wr_en)   busy_d = 1'b0;
    if (i_rsv_set) busy_d = 1'b1;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign o_data = data_q;
  assign o_busy = busy_q;
endmodule

module argon_regfile_sb #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int F_IDX      = 7,
  parameter int FLAG_BITS  = 8,
  localparam int IDX_W     = $clog2(NUM_REGS)
) (
  input  logic i_Clk,
  input  logic i_Reset,
  argon_regfile_sb_if.slave bus
);
  localparam logic [IDX_W-1:0] F_SEL = IDX_W'(F_IDX);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [NUM_REGS-1:0]                 busy;

  logic [DATA_WIDTH-1:0] src_a, src_b;
  logic                  blk_a, blk_b;
  logic                  stall, rd_acc, rsv_ok;

  logic                  rd_valid_d, rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_a_d, rd_data_a_q;
  logic [DATA_WIDTH-1:0] rd_data_b_d, rd_data_b_q;

  assign regs[0] = '0;
  assign busy[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      argon_regfile_sb_cell #(
        .DATA_WIDTH (DATA_WIDTH),
        .FLAG_BITS  (FLAG_BITS)
      ) u_cell (
        .i_Clk       (i_Clk),
        .i_Reset     (i_Reset),
        .i_wr_en     (bus.i_wr_valid && (bus.i_wr_idx == IDX_W'(gi))),
        .i_wr_data   (bus.i_wr_data),
        .i_flag_en   (bus.i_flag_wr && (gi == F_IDX)),
        .i_flag_data (bus.i_flag_data),
        .i_rsv_set   (rsv_ok && (bus.i_rsv_idx == IDX_W'(gi))),
        .o_data      (regs[gi]),
        .o_busy      (busy[gi])
      );
    end
  endgenerate

`ifdef REGFILE_BYPASS_EN
  logic [DATA_WIDTH-1:0] wr_merged;
  logic                  byp_a, byp_b;

  // Forwarded value must look exactly like what the register will hold next.
  always_comb begin
    wr_merged = bus.i_wr_data;
    if (bus.i_flag_wr && (bus.i_wr_idx == F_SEL))
      wr_merged[FLAG_BITS-1:0] = bus.i_flag_data;
  end

  assign byp_a = bus.i_wr_valid && (bus.i_wr_idx == bus.i_rd_idx_a) && (bus.i_rd_idx_a != '0);
  assign byp_b = bus.i_wr_valid && (bus.i_wr_idx == bus.i_rd_idx_b) && (bus.i_rd_idx_b != '0);

  assign src_a = byp_a ? wr_merged : regs[bus.i_rd_idx_a];
  assign src_b = byp_b ? wr_merged : regs[bus.i_rd_idx_b];
  assign blk_a = busy[bus.i_rd_idx_a] && !byp_a;
  assign blk_b = busy[bus.i_rd_idx_b] && !byp_b;
`else
  assign src_a = regs[bus.i_rd_idx_a];
  assign src_b = regs[bus.i_rd_idx_b];
  assign blk_a = busy[bus.i_rd_idx_a];
  assign blk_b = busy[bus.i_rd_idx_b];
`endif

  assign stall  = bus.i_rd_req && (blk_a || blk_b);
  assign rd_acc = bus.i_rd_req && !stall;
  // r0 is never busy, so a reservation to it is always ready and sets nothing.
  assign rsv_ok = bus.i_rsv_valid && !busy[bus.i_rsv_idx];

  always_comb begin
    rd_valid_d  = rd_acc;
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    if (rd_acc) begin
      rd_data_a_d = src_a;
      rd_data_b_d = src_b;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      rd_valid_q  <= 1'b0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
    end else begin
      rd_valid_q  <= rd_valid_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
    end
  end

  assign bus.o_rd_stall  = stall;
  assign bus.o_rsv_ready = rsv_ok;
  assign bus.o_rd_valid  = rd_valid_q;
  assign bus.o_rd_data_a = rd_data_a_q;
  assign bus.o_rd_data_b = rd_data_b_q;
  assign bus.o_busy      = busy;
endmodule

// File: tb/tb_argon_regfile_sb.sv
// Self-checking bench for argon_regfile_sb: directed scenarios plus a
// randomized run against an array-based reference model.
module tb_argon_regfile_sb;
  localparam int DW = 16;
  localparam int NR = 8;
  localparam int FI = 7;
  localparam int FB = 8;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  argon_regfile_sb_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .FLAG_BITS(FB)) bus ();

  argon_regfile_sb #(.DATA_WIDTH(DW), .NUM_REGS(NR), .F_IDX(FI), .FLAG_BITS(FB)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] mreg  [NR];
  bit            mbusy [NR];
  logic [DW-1:0] m_a, m_b;
  bit            m_vld;

  task automatic idle();
    bus.i_rd_req = 0; bus.i_rd_idx_a = '0; bus.i_rd_idx_b = '0;
    bus.i_rsv_valid = 0; bus.i_rsv_idx = '0;
    bus.i_wr_valid = 0; bus.i_wr_idx = '0; bus.i_wr_data = '0;
    bus.i_flag_wr = 0; bus.i_flag_data = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int idx, input logic [DW-1:0] d);
    bus.i_wr_valid = 1; bus.i_wr_idx = IW'(idx); bus.i_wr_data = d;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); tick(); rst = 0;
    for (int i = 0; i < NR; i++) begin mreg[i] = '0; mbusy[i] = 0; end
    m_a = '0; m_b = '0; m_vld = 0;
  endtask

  // Reference model: what a source reads this cycle and whether it blocks.
  function automatic bit byp(input logic [IW-1:0] idx);
`ifdef REGFILE_BYPASS_EN
    return bus.i_wr_valid && bus.i_wr_idx == idx && idx != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] rd_val(input logic [IW-1:0] idx);
    logic [DW-1:0] v;
    if (idx == 0) return '0;
    if (byp(idx)) begin
      v = bus.i_wr_data;
      if (bus.i_flag_wr && idx == FI) v[FB-1:0] = bus.i_flag_data;
      return v;
    end
    return mreg[idx];
  endfunction

  function automatic bit blocked(input logic [IW-1:0] idx);
    return mbusy[idx] && !byp(idx);
  endfunction

  task automatic test_reset();
    idle(); rst = 1; tick(); tick();
    n_total++; if (bus.o_busy !== 8'h00) $display("FAIL reset_busy got=%h exp=00", bus.o_busy); else n_pass++;
    n_total++; if (bus.o_rd_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.o_rd_valid); else n_pass++;
    n_total++; if (bus.o_rd_data_a !== 16'h0 || bus.o_rd_data_b !== 16'h0)
      $display("FAIL reset_data got=%h/%h exp=0000/0000", bus.o_rd_data_a, bus.o_rd_data_b); else n_pass++;
    rst = 0;
  endtask

  task automatic test_basic_read();
    wr(3, 16'h1234); tick(); idle();
    bus.i_rd_req = 1; bus.i_rd_idx_a = 3; bus.i_rd_idx_b = 0; #3;
    n_total++; if (bus.o_rd_stall !== 1'b0) $display("FAIL basic_stall got=%b exp=0", bus.o_rd_stall); else n_pass++;
    tick(); idle();
    n_total++; if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data_a !== 16'h1234 || bus.o_rd_data_b !== 16'h0)
      $display("FAIL basic_read got=%b %h %h exp=1 1234 0000", bus.o_rd_valid, bus.o_rd_data_a, bus.o_rd_data_b); else n_pass++;
    tick();
    n_total++; if (bus.o_rd_valid !== 1'b0 || bus.o_rd_data_a !== 16'h1234)
      $display("FAIL basic_hold got=%b %h exp=0 1234", bus.o_rd_valid, bus.o_rd_data_a); else n_pass++;
  endtask

  task automatic test_stall_release();
    bus.i_rsv_valid = 1; bus.i_rsv_idx = 2; #3;
    n_total++; if (bus.o_rsv_ready !== 1'b1) $display("FAIL rsv2_ready got=%b exp=1", bus.o_rsv_ready); else n_pass++;
    tick(); idle();
    n_total++; if (bus.o_busy !== 8'h04) $display("FAIL rsv2_busy got=%h exp=04", bus.o_busy); else n_pass++;
    bus.i_rd_req = 1; bus.i_rd_idx_a = 2; bus.i_rd_idx_b = 0; #3;
    n_total++; if (bus.o_rd_stall !== 1'b1) $display("FAIL busy_stall got=%b exp=1", bus.o_rd_stall); else n_pass++;
    tick();
    n_total++; if (bus.o_rd_valid !== 1'b0) $display("FAIL stalled_valid got=%b exp=0", bus.o_rd_valid); else n_pass++;
    wr(2, 16'hBEEF); #3;
`ifdef REGFILE_BYPASS_EN
    n_total++; if (bus.o_rd_stall !== 1'b0) $display("FAIL byp_stall got=%b exp=0", bus.o_rd_stall); else n_pass++;
    tick(); idle();
`else
    n_total++; if (bus.o_rd_stall !== 1'b1) $display("FAIL wr_cycle_stall got=%b exp=1", bus.o_rd_stall); else n_pass++;
    tick(); bus.i_wr_valid = 0; #3;
    n_total++; if (bus.o_rd_stall !== 1'b0) $display("FAIL post_wr_stall got=%b exp=0", bus.o_rd_stall); else n_pass++;
    tick(); idle();
`endif
    n_total++; if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data_a !== 16'hBEEF)
      $display("FAIL release_read got=%b %h exp=1 beef", bus.o_rd_valid, bus.o_rd_data_a); else n_pass++;
    n_total++; if (bus.o_busy !== 8'h00) $display("FAIL release_busy got=%h exp=00", bus.o_busy); else n_pass++;
  endtask

  task automatic test_reserve_conflict();
    bus.i_rsv_valid = 1; bus.i_rsv_idx = 5; tick(); #3;
    n_total++; if (bus.o_rsv_ready !== 1'b0) $display("FAIL rsv_twice got=%b exp=0", bus.o_rsv_ready); else n_pass++;
    tick(); idle(); wr(5, 16'h0505); tick(); idle();
    n_total++; if (bus.o_busy !== 8'h00) $display("FAIL wr_clear got=%h exp=00", bus.o_busy); else n_pass++;
    wr(5, 16'h5A5A); bus.i_rsv_valid = 1; bus.i_rsv_idx = 5; #3;
    n_total++; if (bus.o_rsv_ready !== 1'b1) $display("FAIL wr_rsv_ready got=%b exp=1", bus.o_rsv_ready); else n_pass++;
    tick(); idle();
    n_total++; if (bus.o_busy !== 8'h20) $display("FAIL wr_rsv_busy got=%h exp=20", bus.o_busy); else n_pass++;
    bus.i_rsv_valid = 1; bus.i_rsv_idx = 0; #3;
    n_total++; if (bus.o_rsv_ready !== 1'b1) $display("FAIL rsv_r0_ready got=%b exp=1", bus.o_rsv_ready); else n_pass++;
    tick(); idle();
    n_total++; if (bus.o_busy !== 8'h20) $display("FAIL rsv_r0_busy got=%h exp=20", bus.o_busy); else n_pass++;
    wr(5, 16'h0055); tick(); idle();
  endtask

  task automatic test_flags();
    wr(7, 16'hAB00); tick(); idle();
    wr(7, 16'h1200); bus.i_flag_wr = 1; bus.i_flag_data = 8'h5C; tick(); idle();
    n_total++; if (bus.o_busy[7] !== 1'b0) $display("FAIL flag_busy got=%b exp=0", bus.o_busy[7]); else n_pass++;
    bus.i_rd_req = 1; bus.i_rd_idx_a = 7; bus.i_rd_idx_b = 0; tick(); idle();
    n_total++; if (bus.o_rd_data_a !== 16'h125C) $display("FAIL flag_merge got=%h exp=125c", bus.o_rd_data_a); else n_pass++;
    bus.i_rsv_valid = 1; bus.i_rsv_idx = 7; tick(); idle();
    bus.i_flag_wr = 1; bus.i_flag_data = 8'h33; tick(); idle();
    n_total++; if (bus.o_busy[7] !== 1'b1) $display("FAIL flag_keeps_busy got=%b exp=1", bus.o_busy[7]); else n_pass++;
    wr(7, 16'h0000); tick(); idle();
  endtask

  task automatic test_reset_mid();
    wr(6, 16'h6666); tick(); idle();
    bus.i_rsv_valid = 1; bus.i_rsv_idx = 1; tick();
    bus.i_rsv_idx = 4; tick(); idle();
    n_total++; if (bus.o_busy !== 8'h12) $display("FAIL mid_busy got=%h exp=12", bus.o_busy); else n_pass++;
    bus.i_rd_req = 1; bus.i_rd_idx_a = 6; bus.i_rd_idx_b = 3; tick(); #3;
    rst = 1; #1;
    n_total++; if (bus.o_busy !== 8'h00 || bus.o_rd_valid !== 1'b0 || bus.o_rd_data_a !== 16'h0 || bus.o_rd_data_b !== 16'h0)
      $display("FAIL mid_reset got=%h %b %h %h exp=00 0 0000 0000", bus.o_busy, bus.o_rd_valid, bus.o_rd_data_a, bus.o_rd_data_b); else n_pass++;
    tick(); idle(); rst = 0;
    for (int i = 1; i < NR; i++) begin
      bus.i_rd_req = 1; bus.i_rd_idx_a = IW'(i); bus.i_rd_idx_b = IW'(NR - i); tick();
      n_total++; if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data_a !== 16'h0 || bus.o_rd_data_b !== 16'h0)
        $display("FAIL post_reset_r%0d got=%b %h %h exp=1 0000 0000", i, bus.o_rd_valid, bus.o_rd_data_a, bus.o_rd_data_b); else n_pass++;
    end
    idle();
  endtask

  task automatic test_random();
    bit            e_stall, e_rdy, acc;
    logic [NR-1:0] e_busy;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      bus.i_rd_req    = ($urandom_range(9) < 7);
      bus.i_rd_idx_a  = IW'($urandom);
      bus.i_rd_idx_b  = IW'($urandom);
      bus.i_rsv_valid = ($urandom_range(9) < 4);
      bus.i_rsv_idx   = IW'($urandom);
      bus.i_wr_valid  = ($urandom_range(9) < 5);
      bus.i_wr_idx    = IW'($urandom);
      bus.i_wr_data   = DW'($urandom);
      bus.i_flag_wr   = ($urandom_range(9) < 2);
      bus.i_flag_data = FB'($urandom);
      #3;
      e_stall = bus.i_rd_req && (blocked(bus.i_rd_idx_a) || blocked(bus.i_rd_idx_b));
      e_rdy   = bus.i_rsv_valid && !mbusy[bus.i_rsv_idx];
      for (int i = 0; i < NR; i++) e_busy[i] = mbusy[i];
      n_total++; if (bus.o_rd_stall !== e_stall)
        $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, bus.o_rd_stall, e_stall); else n_pass++;
      n_total++; if (bus.o_rsv_ready !== e_rdy)
        $display("FAIL rnd_rsv c=%0d got=%b exp=%b", c, bus.o_rsv_ready, e_rdy); else n_pass++;
      n_total++; if (bus.o_busy !== e_busy)
        $display("FAIL rnd_busy c=%0d got=%h exp=%h", c, bus.o_busy, e_busy); else n_pass++;
      acc = bus.i_rd_req && !e_stall;
      m_vld = acc;
      if (acc) begin m_a = rd_val(bus.i_rd_idx_a); m_b = rd_val(bus.i_rd_idx_b); end
      if (bus.i_wr_valid && bus.i_wr_idx != 0) begin
        mreg[bus.i_wr_idx] = bus.i_wr_data; mbusy[bus.i_wr_idx] = 0;
      end
      if (bus.i_flag_wr) mreg[FI][FB-1:0] = bus.i_flag_data;
      if (e_rdy && bus.i_rsv_idx != 0) mbusy[bus.i_rsv_idx] = 1;
      tick();
      n_total++; if (bus.o_rd_valid !== m_vld || bus.o_rd_data_a !== m_a || bus.o_rd_data_b !== m_b)
        $display("FAIL rnd_read c=%0d got=%b %h %h exp=%b %h %h", c,
                 bus.o_rd_valid, bus.o_rd_data_a, bus.o_rd_data_b, m_vld, m_a, m_b); else n_pass++;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_basic_read();
    test_stall_release();
    test_reserve_conflict();
    test_flags();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
